// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register.
// The fetch PC drives a single-outstanding read on an SRAM-like bus. Returned
// words go straight into IF/ID when the slot is free. Otherwise they park in a
// one-entry hold buffer. A redirect restarts fetch at a new PC and cancels any
// in-flight word.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall_d         decode stalled, IF/ID holds its contents
//   flush_d         clear IF/ID (bubble)
//   redirect_valid  restart fetch at redirect_pc
//   redirect_pc     word-aligned redirect target
//   inst_req        read request
//   inst_addr       read address (current fetch PC)
//   inst_addr_ok    address accepted this cycle
//   inst_data_ok    read data valid this cycle
//   inst_rdata      read data
//   valid_d         IF/ID holds a real instruction
//   instr_d         IF/ID instruction, reads 0 when not valid
//   pc_d            PC of instr_d
//   op_d, rs_d, rt_d  decoder fields taken from instr_d
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [5:0]  op_d,
  output logic [5:0]  rs_d,
  output logic [5:0]  rt_d
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        discard, discard_next;
  logic [31:0] hold_data, hold_pc;
  logic        hold_capture;
  logic        load;
  logic [31:0] load_data, load_pc;
  logic [31:0] instr_q;
  logic        slot_free;

  // IF/ID can take a new word when it is empty or decode is moving.
  assign slot_free = !valid_d || !stall_d;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;
    hold_capture  = 1'b0;
    load          = 1'b0;
    load_data     = inst_rdata;
    load_pc       = fetch_pc;
    inst_req      = 1'b0;
    unique case (state)
      S_REQ: begin
        inst_req = 1'b1;
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          // Once the old address has been accepted, its data must be thrown away.
          if (inst_addr_ok) begin
            discard_next = 1'b1;
            state_next   = S_WAIT;
          end
        end else if (inst_addr_ok) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_next = S_REQ;
          if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            discard_next  = 1'b0;
          end else if (discard) begin
            discard_next = 1'b0;
          end else if (slot_free && !flush_d) begin
            load          = 1'b1;
            fetch_pc_next = fetch_pc + 32'd4;
          end else begin
            hold_capture = 1'b1;
            state_next   = S_HOLD;
          end
        end else if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          discard_next  = 1'b1;
        end
      end
      S_HOLD: begin
        load_data = hold_data;
        load_pc   = hold_pc;
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = S_REQ;
        end else if (slot_free && !flush_d) begin
          load          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
      hold_data <= 32'd0;
      hold_pc   <= 32'd0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
      if (hold_capture) begin
        hold_data <= inst_rdata;
        hold_pc   <= fetch_pc;
      end
    end
  end

  // IF/ID register: flush beats load, load beats stall-hold, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d <= 1'b0;
      instr_q <= 32'd0;
      pc_d    <= 32'd0;
    end else if (flush_d) begin
      valid_d <= 1'b0;
    end else if (load) begin
      valid_d <= 1'b1;
      instr_q <= load_data;
      pc_d    <= load_pc;
    end else if (!(stall_d && valid_d)) begin
      valid_d <= 1'b0;
    end
  end

  assign inst_addr = fetch_pc;
  // An empty slot presents a NOP to decode.
  assign instr_d   = valid_d ? instr_q : 32'd0;
  assign op_d      = instr_d[31:26];
  assign rs_d      = {1'b0, instr_d[25:21]};
  assign rt_d      = {1'b0, instr_d[20:16]};

endmodule

// File: tb/tb_inst_fetch_stage.sv
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;

  logic        inst_req, valid_d;
  logic [31:0] inst_addr, instr_d, pc_d;
  logic [5:0]  op_d, rs_d, rt_d;

  logic        inst_req2, valid_d2;
  logic [31:0] inst_addr2, instr_d2, pc_d2;
  logic [5:0]  op_d2, rs_d2, rt_d2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .op_d(op_d), .rs_d(rs_d), .rt_d(rt_d)
  );

  inst_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req2), .inst_addr(inst_addr2),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .valid_d(valid_d2), .instr_d(instr_d2), .pc_d(pc_d2),
    .op_d(op_d2), .rs_d(rs_d2), .rt_d(rt_d2)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    next_cycle(); next_cycle();
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_d); end
    n_checks++; if (instr_d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instr_d); end
    n_checks++; if (pc_d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc_d: got %h expected 00000000", pc_d); end
    rst = 1'b0;
    next_cycle();
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'hBFC0_0000) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected bfc00000", inst_addr); end
  endtask

  task automatic test_zero_wait();
    inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2001_0005;
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL zw_wait_req: got %b expected 0", inst_req); end
    next_cycle();
    inst_data_ok = 1'b0;
    n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL zw_valid: got %b expected 1", valid_d); end
    n_checks++; if (instr_d !== 32'h2001_0005) begin n_fail++; $display("[TB] FAIL zw_instr: got %h expected 20010005", instr_d); end
    n_checks++; if (op_d !== 6'h08) begin n_fail++; $display("[TB] FAIL zw_op: got %h expected 08", op_d); end
    n_checks++; if (rs_d !== 6'h00) begin n_fail++; $display("[TB] FAIL zw_rs: got %h expected 00", rs_d); end
    n_checks++; if (rt_d !== 6'h01) begin n_fail++; $display("[TB] FAIL zw_rt: got %h expected 01", rt_d); end
    n_checks++; if (pc_d !== 32'hBFC0_0000) begin n_fail++; $display("[TB] FAIL zw_pc_d: got %h expected bfc00000", pc_d); end
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL zw_next_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'hBFC0_0004) begin n_fail++; $display("[TB] FAIL zw_next_addr: got %h expected bfc00004", inst_addr); end
  endtask

  task automatic test_stall_hold();
    stall_d = 1'b1; inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C22_0000;
    next_cycle();
    inst_data_ok = 1'b0; inst_rdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_hold_req[%0d]: got %b expected 0", i, inst_req); end
      n_checks++; if (instr_d !== 32'h2001_0005) begin n_fail++; $display("[TB] FAIL stall_hold_instr[%0d]: got %h expected 20010005", i, instr_d); end
      n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold_valid[%0d]: got %b expected 1", i, valid_d); end
      if (i == 1) stall_d = 1'b0;
      next_cycle();
    end
    n_checks++; if (instr_d !== 32'h8C22_0000) begin n_fail++; $display("[TB] FAIL stall_release_instr: got %h expected 8c220000", instr_d); end
    n_checks++; if (pc_d !== 32'hBFC0_0004) begin n_fail++; $display("[TB] FAIL stall_release_pc_d: got %h expected bfc00004", pc_d); end
    n_checks++; if (op_d !== 6'h23 || rs_d !== 6'h01 || rt_d !== 6'h02) begin n_fail++; $display("[TB] FAIL stall_release_fields: got %h/%h/%h expected 23/01/02", op_d, rs_d, rt_d); end
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'hBFC0_0008) begin n_fail++; $display("[TB] FAIL stall_release_addr: got %h expected bfc00008", inst_addr); end
  endtask

  task automatic test_redirect_wait();
    // Decode stalls so IF/ID keeps the current word; the discarded one must not replace it.
    stall_d = 1'b1; inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    next_cycle();
    redirect_valid = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rdw_wait_req: got %b expected 0", inst_req); end
    next_cycle();
    inst_data_ok = 1'b0;
    n_checks++; if (instr_d !== 32'h8C22_0000) begin n_fail++; $display("[TB] FAIL rdw_instr: got %h expected 8c220000", instr_d); end
    n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL rdw_valid: got %b expected 1", valid_d); end
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rdw_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'h8000_0100) begin n_fail++; $display("[TB] FAIL rdw_addr: got %h expected 80000100", inst_addr); end
    stall_d = 1'b0;
  endtask

  task automatic test_redirect_req();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    next_cycle();
    redirect_valid = 1'b0;
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rdr_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'h8000_0200) begin n_fail++; $display("[TB] FAIL rdr_addr: got %h expected 80000200", inst_addr); end
    inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0123_4567;
    next_cycle();
    inst_data_ok = 1'b0;
    n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL rdr_valid: got %b expected 1", valid_d); end
    n_checks++; if (instr_d !== 32'h0123_4567) begin n_fail++; $display("[TB] FAIL rdr_instr: got %h expected 01234567", instr_d); end
    n_checks++; if (pc_d !== 32'h8000_0200) begin n_fail++; $display("[TB] FAIL rdr_pc_d: got %h expected 80000200", pc_d); end
    n_checks++; if (op_d !== 6'h00 || rs_d !== 6'h09 || rt_d !== 6'h03) begin n_fail++; $display("[TB] FAIL rdr_fields: got %h/%h/%h expected 00/09/03", op_d, rs_d, rt_d); end
  endtask

  task automatic test_flush();
    inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hAABB_CCDD; flush_d = 1'b1;
    next_cycle();
    inst_data_ok = 1'b0; flush_d = 1'b0;
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b expected 0", valid_d); end
    n_checks++; if (instr_d !== 32'd0) begin n_fail++; $display("[TB] FAIL flush_instr: got %h expected 00000000", instr_d); end
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_hold_req: got %b expected 0", inst_req); end
    next_cycle();
    n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_deliver_valid: got %b expected 1", valid_d); end
    n_checks++; if (instr_d !== 32'hAABB_CCDD) begin n_fail++; $display("[TB] FAIL flush_deliver_instr: got %h expected aabbccdd", instr_d); end
    n_checks++; if (pc_d !== 32'h8000_0204) begin n_fail++; $display("[TB] FAIL flush_deliver_pc_d: got %h expected 80000204", pc_d); end
    n_checks++; if (inst_addr !== 32'h8000_0208 || inst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_next_req: got %h/%b expected 80000208/1", inst_addr, inst_req); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_reset_valid: got %b expected 0", valid_d); end
    n_checks++; if (inst_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_first_addr: got %h expected fffffffc", inst_addr2); end
    inst_addr_ok = 1'b1;
    next_cycle();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0000;
    next_cycle();
    inst_data_ok = 1'b0;
    n_checks++; if (inst_addr2 !== 32'h0000_0000) begin n_fail++; $display("[TB] FAIL wrap_second_addr: got %h expected 00000000", inst_addr2); end
    n_checks++; if (pc_d2 !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_pc_d: got %h expected fffffffc", pc_d2); end
    n_checks++; if (inst_addr !== 32'hBFC0_0004) begin n_fail++; $display("[TB] FAIL wrap_default_addr: got %h expected bfc00004", inst_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_req();
    test_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
